ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_motion.sv | 191 +++++++++++++++++++
 tb/tb_ball_motion.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: ball position/direction engine for a two-paddle game.
// Ports: clk, rst (async high), pause; left/right_paddle_row in;
//        ball_center_row/col, ball_direction, score_left/right,
//        in_play out.
module ball_motion #(
    parameter int DISP_COLS     = 600,
    parameter int DISP_ROWS     = 800,
    parameter int BALL_R        = 4,
    parameter int PADDLE_HALF   = 40,
    parameter int PADDLE_FACE_L = 20,
    parameter int PADDLE_FACE_R = 579,
    parameter int SCALER        = 12000,
    parameter int SERVE_TICKS   = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic [11:0] left_paddle_row,
    input  logic [11:0] right_paddle_row,
    output logic [11:0] ball_center_row,
    output logic [11:0] ball_center_col,
    output logic [1:0]  ball_direction,
    output logic        score_left,
    output logic        score_right,
    output logic        in_play
);

    localparam logic [11:0] ROW_C    = 12'(DISP_ROWS / 2);
    localparam logic [11:0] COL_C    = 12'(DISP_COLS / 2);
    localparam logic [11:0] ROW_TOP  = 12'(BALL_R);
    localparam logic [11:0] ROW_TOP1 = 12'(BALL_R + 1);
    localparam logic [11:0] ROW_BOT  = 12'(DISP_ROWS - 1 - BALL_R);
    localparam logic [11:0] COL_LMIS = 12'(BALL_R);
    localparam logic [11:0] COL_RMIS = 12'(DISP_COLS - 1 - BALL_R);
    localparam logic [11:0] COL_LHIT = 12'(PADDLE_FACE_L + BALL_R);
    localparam logic [11:0] COL_RHIT = 12'(PADDLE_FACE_R - BALL_R);
    localparam logic [12:0] HIT_DIST = 13'(PADDLE_HALF + BALL_R);
    localparam logic [19:0] TICK_MAX = 20'(SCALER - 1);
    localparam logic [15:0] SRV_LAST = 16'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        SERVE_WAIT,
        MOVING,
        SCORED
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] serve_cnt_q, serve_cnt_d;
    logic [11:0] row_q, row_d;
    logic [11:0] col_q, col_d;
    logic [1:0]  dir_q, dir_d;
    logic        score_l_q, score_l_d;
    logic        score_r_q, score_r_d;
    logic        tick;

    logic [12:0] l_diff, r_diff;
    logic [12:0] l_abs, r_abs;
    logic        l_near, r_near;

    // Tick strobe; the counter freezes while paused so motion
    // resumes with the same phase.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick       = 1'b0;
        if (!pause) begin
            if (tick_cnt_q == TICK_MAX) begin
                tick_cnt_d = '0;
                tick       = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 20'd1;
            end
        end
    end

    // 13-bit absolute difference so a paddle near row 0 cannot wrap.
    always_comb begin
        l_diff = {1'b0, row_q} - {1'b0, left_paddle_row};
        r_diff = {1'b0, row_q} - {1'b0, right_paddle_row};
        l_abs  = l_diff[12] ? (13'd0 - l_diff) : l_diff;
        r_abs  = r_diff[12] ? (13'd0 - r_diff) : r_diff;
        l_near = (l_abs <= HIT_DIST);
        r_near = (r_abs <= HIT_DIST);
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        dir_d       = dir_q;
        score_l_d   = 1'b0;
        score_r_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                SERVE_WAIT: begin
                    row_d = ROW_C;
                    col_d = COL_C;
                    if (serve_cnt_q == SRV_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = MOVING;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 16'd1;
                    end
                end
                MOVING: begin
                    // A miss freezes the ball where it left the field.
                    if (!dir_q[0] && col_q == COL_LMIS) begin
                        score_r_d = 1'b1;
                        state_d   = SCORED;
                    end else if (dir_q[0] && col_q == COL_RMIS) begin
                        score_l_d = 1'b1;
                        state_d   = SCORED;
                    end else begin
                        // Vertical and horizontal bounces are independent.
                        if (dir_q[1]) begin
                            if (row_q == ROW_BOT) begin
                                row_d    = row_q - 12'd1;
                                dir_d[1] = 1'b0;
                            end else begin
                                row_d = row_q + 12'd1;
                            end
                        end else begin
                            if (row_q == ROW_TOP) begin
                                row_d    = ROW_TOP1;
                                dir_d[1] = 1'b1;
                            end else begin
                                row_d = row_q - 12'd1;
                            end
                        end
                        if (dir_q[0]) begin
                            if (col_q == COL_RHIT && r_near) begin
                                col_d    = col_q - 12'd1;
                                dir_d[0] = 1'b0;
                            end else begin
                                col_d = col_q + 12'd1;
                            end
                        end else begin
                            if (col_q == COL_LHIT && l_near) begin
                                col_d    = col_q + 12'd1;
                                dir_d[0] = 1'b1;
                            end else begin
                                col_d = col_q - 12'd1;
                            end
                        end
                    end
                end
                SCORED: begin
                    row_d    = ROW_C;
                    col_d    = COL_C;
                    // Serve heads toward the side that just missed.
                    dir_d[0] = (col_q >= COL_C);
                    state_d  = SERVE_WAIT;
                end
                default: begin
                    state_d = SERVE_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SERVE_WAIT;
            tick_cnt_q  <= '0;
            serve_cnt_q <= '0;
            row_q       <= ROW_C;
            col_q       <= COL_C;
            dir_q       <= 2'b01;
            score_l_q   <= 1'b0;
            score_r_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            serve_cnt_q <= serve_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dir_q       <= dir_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    assign ball_center_row = row_q;
    assign ball_center_col = col_q;
    assign ball_direction  = dir_q;
    assign score_left      = score_l_q;
    assign score_right     = score_r_q;
    assign in_play         = (state_q == MOVING);

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed vectors for ball_motion (SCALER=4,
// SERVE_TICKS=3); a second instance covers the wall+paddle corner.
module tb_ball_motion;

    logic        clk;
    logic        rst;
    logic        pause;
    logic [11:0] lp, rp;
    logic [11:0] row, col;
    logic [1:0]  dir;
    logic        sc_l, sc_r, play;

    logic [11:0] lp2, rp2;
    logic [11:0] row2, col2;
    logic [1:0]  dir2;
    logic        sc_l2, sc_r2, play2;

    int total;
    int bad;

    ball_motion #(
        .SCALER      (4),
        .SERVE_TICKS (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pause            (pause),
        .left_paddle_row  (lp),
        .right_paddle_row (rp),
        .ball_center_row  (row),
        .ball_center_col  (col),
        .ball_direction   (dir),
        .score_left       (sc_l),
        .score_right      (sc_r),
        .in_play          (play)
    );

    // Small field: start (52,40) reaches the right face on the
    // row-col=-20 diagonal and returns to (4,24).
    ball_motion #(
        .DISP_COLS     (80),
        .DISP_ROWS     (104),
        .PADDLE_FACE_R (60),
        .SCALER        (4),
        .SERVE_TICKS   (3)
    ) dut2 (
        .clk              (clk),
        .rst              (rst),
        .pause            (pause),
        .left_paddle_row  (lp2),
        .right_paddle_row (rp2),
        .ball_center_row  (row2),
        .ball_center_col  (col2),
        .ball_direction   (dir2),
        .score_left       (sc_l2),
        .score_right      (sc_r2),
        .in_play          (play2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ticks;
        logic [11:0] lp;
        logic [11:0] rp;
        logic [11:0] row;
        logic [11:0] col;
        logic [1:0]  dir;
        logic        play;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        clk_n(4 * n);
    endtask

    task automatic chk_pos(input string tag, input int r, input int c,
                           input int d);
        chk({tag, "_row"}, int'(row), r);
        chk({tag, "_col"}, int'(col), c);
        chk({tag, "_dir"}, int'(dir), d);
    endtask

    task automatic chk_reset(input string tag);
        chk_pos(tag, 400, 300, 1);
        chk({tag, "_scl"}, int'(sc_l), 0);
        chk({tag, "_scr"}, int'(sc_r), 0);
        chk({tag, "_play"}, int'(play), 0);
    endtask

    task automatic run_tbl(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            lp = tbl[i].lp;
            rp = tbl[i].rp;
            ticks(tbl[i].ticks);
            chk_pos($sformatf("v%0d", i), int'(tbl[i].row),
                    int'(tbl[i].col), int'(tbl[i].dir));
            chk($sformatf("v%0d_play", i), int'(play), int'(tbl[i].play));
            chk($sformatf("v%0d_scr", i), int'(sc_r), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;

        // Serve and first steps, right paddle hit at distance 44.
        tbl[0]  = '{3,   12'd0,   12'd169, 12'd400, 12'd300, 2'b01, 1'b1};
        tbl[1]  = '{1,   12'd0,   12'd169, 12'd399, 12'd301, 2'b01, 1'b1};
        tbl[2]  = '{1,   12'd0,   12'd169, 12'd398, 12'd302, 2'b01, 1'b1};
        tbl[3]  = '{273, 12'd0,   12'd169, 12'd125, 12'd575, 2'b01, 1'b1};
        tbl[4]  = '{1,   12'd0,   12'd169, 12'd124, 12'd574, 2'b00, 1'b1};
        // Top wall at row 4.
        tbl[5]  = '{120, 12'd0,   12'd169, 12'd4,   12'd454, 2'b00, 1'b1};
        tbl[6]  = '{1,   12'd0,   12'd169, 12'd5,   12'd453, 2'b10, 1'b1};
        // Left paddle at distance 45: ball passes.
        tbl[7]  = '{429, 12'd389, 12'd169, 12'd434, 12'd24,  2'b10, 1'b1};
        tbl[8]  = '{1,   12'd389, 12'd169, 12'd435, 12'd23,  2'b10, 1'b1};
        tbl[9]  = '{19,  12'd389, 12'd169, 12'd454, 12'd4,   2'b10, 1'b1};
        // Second rally: left paddle hit at distance 44.
        tbl[10] = '{276, 12'd632, 12'd0,   12'd676, 12'd24,  2'b10, 1'b1};
        tbl[11] = '{1,   12'd632, 12'd0,   12'd677, 12'd25,  2'b11, 1'b1};
        tbl[12] = '{1,   12'd632, 12'd0,   12'd678, 12'd26,  2'b11, 1'b1};
        tbl[13] = '{1,   12'd632, 12'd0,   12'd679, 12'd27,  2'b11, 1'b1};

        rst   = 1'b1;
        pause = 1'b0;
        lp    = 12'd0;
        rp    = 12'd0;
        lp2   = 12'd4;
        rp2   = 12'd36;
        clk_n(3);
        chk_reset("rst");

        @(negedge clk);
        rst = 1'b0;
        clk_n(11);
        chk("serve11_play", int'(play), 0);
        clk_n(1);
        chk("serve12_play", int'(play), 1);
        chk_pos("serve12", 400, 300, 1);
        chk("d2_serve_row", int'(row2), 52);
        chk("d2_serve_col", int'(col2), 40);

        // Corner: top wall and left paddle on the same tick.
        ticks(16);
        chk("d2_a_row", int'(row2), 36);
        chk("d2_a_col", int'(col2), 56);
        ticks(1);
        chk("d2_b_row", int'(row2), 35);
        chk("d2_b_col", int'(col2), 55);
        chk("d2_b_dir", int'(dir2), 0);
        ticks(31);
        chk("d2_c_row", int'(row2), 4);
        chk("d2_c_col", int'(col2), 24);
        ticks(1);
        chk("d2_d_row", int'(row2), 5);
        chk("d2_d_col", int'(col2), 25);
        chk("d2_d_dir", int'(dir2), 3);
        chk_pos("m49", 351, 349, 1);

        // Pause mid-period for 20 clk, then resume on the same phase.
        clk_n(2);
        pause = 1'b1;
        clk_n(20);
        chk_pos("pause", 351, 349, 1);
        chk("pause_play", int'(play), 1);
        pause = 1'b0;
        clk_n(1);
        chk_pos("resume1", 351, 349, 1);
        clk_n(1);
        chk_pos("resume2", 350, 350, 1);

        // Async reset between edges.
        clk_n(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst = 1'b0;

        run_tbl(0, 9);

        // Left miss at col 4.
        ticks(1);
        chk("miss_scr", int'(sc_r), 1);
        chk("miss_scl", int'(sc_l), 0);
        chk("miss_play", int'(play), 0);
        chk("miss_col", int'(col), 4);
        clk_n(1);
        chk("miss_scr_off", int'(sc_r), 0);
        clk_n(3);
        chk_pos("recentre", 400, 300, 2);
        chk("recentre_play", int'(play), 0);
        chk("recentre_scr", int'(sc_r), 0);
        ticks(2);
        chk("wait2_play", int'(play), 0);
        ticks(1);
        chk("reserve_play", int'(play), 1);
        chk_pos("reserve", 400, 300, 2);

        run_tbl(10, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
